programmable_fault_injector: RTL and testbench
==============================================

PROGRAMMABLE_FAULT_INJECTOR -- requirements
Module: programmable_fault_injector

Interface
REQ-001 Parameter CODE_W, default 13, codeword width in bits.
REQ-002 Parameter ADDR_W, default $clog2(CODE_W), bit-address width.
REQ-003 Parameter CNT_W, default 16, width of period and injection counters.
REQ-004 Parameter LFSR_W, default 16, random-mode LFSR width.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 cfg_load  in  1  latch all cfg_* and arm; honoured only in IDLE.
REQ-008 cfg_abort  in  1  return to IDLE from any state.
REQ-009 cfg_mode  in  2  fault mode: 0 SINGLE, 1 DOUBLE, 2 BURST, 3 RANDOM.
REQ-010 cfg_addr1, cfg_addr2  in  ADDR_W each  fixed fault bit addresses.
REQ-011 cfg_burst_len  in  ADDR_W  adjacent bits flipped in BURST, starting at addr1.
REQ-012 cfg_period  in  CNT_W  inject on every Nth accepted word; 0 treated as 1.
REQ-013 cfg_count  in  CNT_W  injections before DONE; 0 = unlimited.
REQ-014 cfg_seed  in  LFSR_W  LFSR seed; zero seed replaced by all-ones.
REQ-015 in_valid, in_ready  in/out  1 each  input handshake.
REQ-016 in_code  in  CODE_W  clean codeword.
REQ-017 out_valid, out_ready  out/in  1 each  output handshake.
REQ-018 out_code  out  CODE_W  in_code XOR out_mask.
REQ-019 out_mask  out  CODE_W  bits flipped in this word.
REQ-020 out_injected  out  1  out_mask nonzero.
REQ-021 inj_count  out  CNT_W  injections performed since cfg_load.
REQ-022 state_o  out  2  IDLE=0, ARMED=1, DONE=2.

Function
REQ-023 Block passes words through a single register stage, latency 1 cycle; in_ready = !out_valid | out_ready; word accepted when in_valid & in_ready.
REQ-024 Output holds stable while out_valid & !out_ready.
REQ-025 IDLE and DONE: accepted words pass unmodified, out_mask = 0.
REQ-026 IDLE -> ARMED on cfg_load; period counter loads cfg_period, inj_count clears, LFSR loads seed.
REQ-027 ARMED: period counter decrements per accepted word; at 1 the word is faulted and counter reloads.
REQ-028 Each faulted word increments inj_count (saturating); when inj_count reaches nonzero cfg_count, ARMED -> DONE in the same cycle the last faulted word is registered.
REQ-029 cfg_abort has priority over cfg_load and over injection; word accepted that cycle passes unmodified.
REQ-030 SINGLE: mask bit addr1. DOUBLE: bits addr1 and addr2, OR-combined (equal addresses flip one bit).
REQ-031 BURST: bits addr1 .. addr1+len-1, truncated at CODE_W-1, no wrap; len 0 = no flip.
REQ-032 RANDOM: LFSR (maximal-length, Fibonacci) advances once per accepted word in ARMED; addr A = low ADDR_W bits, addr B = next ADDR_W bits, each reduced by CODE_W if >= CODE_W; mask = bit A | bit B.
REQ-033 Any fixed address >= CODE_W contributes no flip.
REQ-034 DONE -> IDLE only on cfg_abort or rst.

Reset
REQ-035 rst clears out_valid, out_code, out_mask, out_injected, inj_count to 0, state to IDLE, LFSR to all-ones; in-flight word discarded.

Structure
REQ-036 Mode encodings, state encodings and the LFSR tap table belong in shared package fault_inj_pkg.
REQ-037 Mask generation is the natural sub-module: fault_mask_gen (combinational, mode/addresses/LFSR in, CODE_W mask out).

Verification
REQ-038 SINGLE, addr1=5, period=1, count=3, in_code=0 x4 -> out_code 0x020 three times, then 0x000, state DONE, inj_count 3.
REQ-039 DOUBLE, addr1=addr2=7 -> out_mask 0x080; addr1=2, addr2=11 -> 0x804.
REQ-040 BURST, addr1=10, len=5, CODE_W=13 -> out_mask 0x1C00 (truncated).
REQ-041 period=3, count=0, 9 words -> faults on words 3, 6, 9 only; out_ready held low 4 cycles -> output stable, no word lost.
REQ-042 RANDOM seed 0 -> behaves as seed all-ones; 1000 words: every mask has 1 or 2 bits, all < CODE_W.
REQ-043 cfg_abort mid-ARMED and rst mid-transfer -> IDLE, next word unmodified, outputs cleared per REQ-035.

Source files
------------

// File: rtl/fault_inj_pkg.sv
// Shared encodings for the programmable fault injector: fault modes, FSM
// states and the maximal-length Fibonacci LFSR tap table.
package fault_inj_pkg;

  typedef enum logic [1:0] {
    MODE_SINGLE = 2'd0,
    MODE_DOUBLE = 2'd1,
    MODE_BURST  = 2'd2,
    MODE_RANDOM = 2'd3
  } fault_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } inj_state_e;

  // Tap mask for a left-shifting Fibonacci LFSR: polynomial term x^n maps to
  // bit n-1. Widths missing from the table fall back to the 16-bit taps.
  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      10:      return 32'h0000_0240;
      12:      return 32'h0000_0829;
      16:      return 32'h0000_D008;
      20:      return 32'h0009_0000;
      24:      return 32'h00E1_0000;
      32:      return 32'h8020_0003;
      default: return 32'h0000_D008;
    endcase
  endfunction

endpackage

// File: rtl/fault_mask_gen.sv
// Combinational fault-mask generator: turns the latched mode, fixed
// addresses, burst length and random address bits into a CODE_W flip mask.
module fault_mask_gen
  import fault_inj_pkg::*;
#(
  parameter int CODE_W = 13,
  parameter int ADDR_W = $clog2(CODE_W)
) (
  input  fault_mode_e         mode,
  input  logic [ADDR_W-1:0]   addr1,
  input  logic [ADDR_W-1:0]   addr2,
  input  logic [ADDR_W-1:0]   burst_len,
  input  logic [2*ADDR_W-1:0] rand_bits,
  output logic [CODE_W-1:0]   mask
);

  localparam logic [ADDR_W:0] CODE_LIM = (ADDR_W+1)'(CODE_W);

  // One-hot bit at address a; addresses beyond the codeword give no bit.
  function automatic logic [CODE_W-1:0] onehot(input logic [ADDR_W-1:0] a);
    logic [CODE_W-1:0] m;
    m = '0;
    for (int i = 0; i < CODE_W; i++) begin
      if ((ADDR_W+1)'(i) == {1'b0, a}) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Random addresses span 0..2^ADDR_W-1 < 2*CODE_W, so one subtraction folds them in range.
  function automatic logic [ADDR_W-1:0] fold(input logic [ADDR_W-1:0] a);
    logic [ADDR_W:0] w;
    w = {1'b0, a};
    if (w >= CODE_LIM) w = w - CODE_LIM;
    return w[ADDR_W-1:0];
  endfunction

  // Contiguous run from start for len bits, clipped at the top bit, no wrap.
  function automatic logic [CODE_W-1:0] burst(input logic [ADDR_W-1:0] start,
                                              input logic [ADDR_W-1:0] len);
    logic [CODE_W-1:0] m;
    logic [ADDR_W:0]   lo;
    logic [ADDR_W:0]   hi;
    logic [ADDR_W:0]   idx;
    m  = '0;
    lo = {1'b0, start};
    hi = lo + {1'b0, len};
    for (int i = 0; i < CODE_W; i++) begin
      idx = (ADDR_W+1)'(i);
      if (idx >= lo && idx < hi) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Select the mask shape for the active mode.
  always_comb begin
    mask = '0;
    unique case (mode)
      MODE_SINGLE: mask = onehot(addr1);
      MODE_DOUBLE: mask = onehot(addr1) | onehot(addr2);
      MODE_BURST:  mask = burst(addr1, burst_len);
      MODE_RANDOM: mask = onehot(fold(rand_bits[ADDR_W-1:0])) |
                          onehot(fold(rand_bits[2*ADDR_W-1:ADDR_W]));
      default:     mask = '0;
    endcase
  end

endmodule

// File: rtl/programmable_fault_injector.sv
// Programmable fault injector: a one-deep register slice that XORs a
// configurable fault mask into every Nth accepted codeword while armed.
module programmable_fault_injector
  import fault_inj_pkg::*;
#(
  parameter int CODE_W = 13,
  parameter int ADDR_W = $clog2(CODE_W),
  parameter int CNT_W  = 16,
  parameter int LFSR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_load,
  input  logic              cfg_abort,
  input  logic [1:0]        cfg_mode,
  input  logic [ADDR_W-1:0] cfg_addr1,
  input  logic [ADDR_W-1:0] cfg_addr2,
  input  logic [ADDR_W-1:0] cfg_burst_len,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [CNT_W-1:0]  cfg_count,
  input  logic [LFSR_W-1:0] cfg_seed,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic [CODE_W-1:0] out_mask,
  output logic              out_injected,
  output logic [CNT_W-1:0]  inj_count,
  output logic [1:0]        state_o
);

  localparam logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(lfsr_taps(LFSR_W));

  inj_state_e        state_q, state_d;
  fault_mode_e       mode_q, mode_d;
  logic [ADDR_W-1:0] addr1_q, addr1_d, addr2_q, addr2_d, len_q, len_d;
  logic [CNT_W-1:0]  period_q, period_d, count_q, count_d;
  logic [CNT_W-1:0]  per_cnt_q, per_cnt_d, inj_count_q, inj_count_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic              out_valid_q, out_valid_d;
  logic [CODE_W-1:0] out_code_q, out_code_d, out_mask_q, out_mask_d;

  logic              accept;
  logic              fault_now;
  logic [CNT_W-1:0]  inj_inc;
  logic [CODE_W-1:0] gen_mask;

  fault_mask_gen #(
    .CODE_W (CODE_W),
    .ADDR_W (ADDR_W)
  ) u_mask_gen (
    .mode      (mode_q),
    .addr1     (addr1_q),
    .addr2     (addr2_q),
    .burst_len (len_q),
    .rand_bits (lfsr_q[2*ADDR_W-1:0]),
    .mask      (gen_mask)
  );

  assign in_ready     = !out_valid_q || out_ready;
  assign accept       = in_valid && in_ready;
  // Abort wins over injection: the word accepted alongside it passes clean.
  assign fault_now    = (state_q == ST_ARMED) && accept && !cfg_abort &&
                        (per_cnt_q == CNT_W'(1));
  assign inj_inc      = (inj_count_q == '1) ? inj_count_q : inj_count_q + CNT_W'(1);

  assign out_valid    = out_valid_q;
  assign out_code     = out_code_q;
  assign out_mask     = out_mask_q;
  assign out_injected = |out_mask_q;
  assign inj_count    = inj_count_q;
  assign state_o      = state_q;

  // Next-state logic for the output slice, period counter, LFSR and FSM.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    addr1_d     = addr1_q;
    addr2_d     = addr2_q;
    len_d       = len_q;
    period_d    = period_q;
    count_d     = count_q;
    per_cnt_d   = per_cnt_q;
    inj_count_d = inj_count_q;
    lfsr_d      = lfsr_q;
    out_valid_d = out_valid_q;
    out_code_d  = out_code_q;
    out_mask_d  = out_mask_q;

    if (accept) begin
      out_valid_d = 1'b1;
      out_mask_d  = fault_now ? gen_mask : '0;
      out_code_d  = in_code ^ (fault_now ? gen_mask : '0);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (cfg_abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cfg_load) begin
            state_d     = ST_ARMED;
            mode_d      = fault_mode_e'(cfg_mode);
            addr1_d     = cfg_addr1;
            addr2_d     = cfg_addr2;
            len_d       = cfg_burst_len;
            period_d    = (cfg_period == '0) ? CNT_W'(1) : cfg_period;
            per_cnt_d   = (cfg_period == '0) ? CNT_W'(1) : cfg_period;
            count_d     = cfg_count;
            inj_count_d = '0;
            lfsr_d      = (cfg_seed == '0) ? '1 : cfg_seed;
          end
        end
        ST_ARMED: begin
          if (accept) begin
            lfsr_d    = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
            per_cnt_d = (per_cnt_q == CNT_W'(1)) ? period_q : per_cnt_q - CNT_W'(1);
            if (fault_now) begin
              inj_count_d = inj_inc;
              if (count_q != '0 && inj_inc == count_q) state_d = ST_DONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Control state and output slice; reset drops any in-flight word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      per_cnt_q   <= '0;
      inj_count_q <= '0;
      lfsr_q      <= '1;
      out_valid_q <= 1'b0;
      out_code_q  <= '0;
      out_mask_q  <= '0;
    end else begin
      state_q     <= state_d;
      per_cnt_q   <= per_cnt_d;
      inj_count_q <= inj_count_d;
      lfsr_q      <= lfsr_d;
      out_valid_q <= out_valid_d;
      out_code_q  <= out_code_d;
      out_mask_q  <= out_mask_d;
    end
  end

  // Configuration latched at load; only meaningful once armed, so no reset.
  always_ff @(posedge clk) begin
    mode_q   <= mode_d;
    addr1_q  <= addr1_d;
    addr2_q  <= addr2_d;
    len_q    <= len_d;
    period_q <= period_d;
    count_q  <= count_d;
  end

endmodule

// File: tb/tb_programmable_fault_injector.sv
// Testbench for programmable_fault_injector: mask vector table, hand-built
// corner sequences and randomized traffic against a behavioural model.
module tb_programmable_fault_injector;

  localparam int CODE_W = 13;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 16;
  localparam int LFSR_W = 16;

  logic              clk = 1'b0;
  logic              rst, cfg_load, cfg_abort;
  logic [1:0]        cfg_mode;
  logic [ADDR_W-1:0] cfg_addr1, cfg_addr2, cfg_burst_len;
  logic [CNT_W-1:0]  cfg_period, cfg_count;
  logic [LFSR_W-1:0] cfg_seed;
  logic              in_valid, in_ready, out_valid, out_ready, out_injected;
  logic [CODE_W-1:0] in_code, out_code, out_mask;
  logic [CNT_W-1:0]  inj_count;
  logic [1:0]        state_o;

  int n_err = 0;
  int n_chk = 0;

  // Reference model state
  bit               m_ov;
  logic [CODE_W-1:0] m_code, m_mask;
  logic [CNT_W-1:0] m_inj;
  int               m_st;
  logic [LFSR_W-1:0] m_lfsr;
  int               m_per, m_reload, l_mode, l_a1, l_a2, l_len, l_cnt;

  typedef struct {
    int                mode;
    int                a1;
    int                a2;
    int                len;
    logic [CODE_W-1:0] code;
    logic [CODE_W-1:0] exp_mask;
  } vec_t;
  vec_t tbl[11];

  always #5 clk = ~clk;

  programmable_fault_injector #(
    .CODE_W(CODE_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .LFSR_W(LFSR_W)
  ) dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_abort(cfg_abort),
    .cfg_mode(cfg_mode), .cfg_addr1(cfg_addr1), .cfg_addr2(cfg_addr2),
    .cfg_burst_len(cfg_burst_len), .cfg_period(cfg_period), .cfg_count(cfg_count),
    .cfg_seed(cfg_seed), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
    .out_mask(out_mask), .out_injected(out_injected), .inj_count(inj_count),
    .state_o(state_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [CODE_W-1:0] bit_of(input int a);
    logic [CODE_W-1:0] one;
    one = 1;
    return (a >= 0 && a < CODE_W) ? (one << a) : '0;
  endfunction

  // Mask as the rules describe it, independent of any implementation detail.
  function automatic logic [CODE_W-1:0] ref_mask(input int mode, input int a1, input int a2,
                                                 input int len, input logic [LFSR_W-1:0] lf);
    logic [CODE_W-1:0] m;
    m = '0;
    case (mode)
      0: m = bit_of(a1);
      1: m = bit_of(a1) | bit_of(a2);
      2: for (int k = 0; k < len; k++) m |= bit_of(a1 + k);
      default: m = bit_of(int'(lf[3:0]) % CODE_W) | bit_of(int'(lf[7:4]) % CODE_W);
    endcase
    return m;
  endfunction

  // Advance the model by one clock using the inputs currently applied,
  // then clock the DUT and compare every output against the model.
  task automatic cyc();
    bit acc, fault;
    logic [CODE_W-1:0] fm;
    acc = in_valid && (!m_ov || out_ready);
    if (rst) begin
      m_ov = 0; m_code = '0; m_mask = '0; m_inj = '0; m_st = 0; m_lfsr = '1;
    end else begin
      fault = (m_st == 1) && acc && !cfg_abort && (m_per == 1);
      fm = fault ? ref_mask(l_mode, l_a1, l_a2, l_len, m_lfsr) : '0;
      if (acc) begin
        m_ov = 1; m_code = in_code ^ fm; m_mask = fm;
      end else if (out_ready) begin
        m_ov = 0;
      end
      if (cfg_abort) begin
        m_st = 0;
      end else if (m_st == 0) begin
        if (cfg_load) begin
          l_mode = int'(cfg_mode); l_a1 = int'(cfg_addr1); l_a2 = int'(cfg_addr2);
          l_len = int'(cfg_burst_len); l_cnt = int'(cfg_count);
          m_reload = (cfg_period == 0) ? 1 : int'(cfg_period);
          m_per = m_reload; m_inj = '0;
          m_lfsr = (cfg_seed == 0) ? '1 : cfg_seed;
          m_st = 1;
        end
      end else if (m_st == 1 && acc) begin
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[14] ^ m_lfsr[12] ^ m_lfsr[3]};
        m_per = (m_per == 1) ? m_reload : m_per - 1;
        if (fault) begin
          if (m_inj != 16'hFFFF) m_inj = m_inj + 16'd1;
          if (l_cnt != 0 && int'(m_inj) == l_cnt) m_st = 2;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("m_out_valid", 32'(out_valid), 32'(m_ov));
    chk("m_out_code", 32'(out_code), 32'(m_code));
    chk("m_out_mask", 32'(out_mask), 32'(m_mask));
    chk("m_out_injected", 32'(out_injected), 32'(m_mask != 0));
    chk("m_inj_count", 32'(inj_count), 32'(m_inj));
    chk("m_state", 32'(state_o), 32'(m_st));
    chk("m_in_ready", 32'(in_ready), 32'(!m_ov || out_ready));
  endtask

  task automatic cfg_set(input int mode, input int a1, input int a2, input int len,
                         input int per, input int cnt, input int seed);
    cfg_mode = 2'(mode); cfg_addr1 = 4'(a1); cfg_addr2 = 4'(a2); cfg_burst_len = 4'(len);
    cfg_period = 16'(per); cfg_count = 16'(cnt); cfg_seed = 16'(seed);
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 0; cfg_load = 0; cfg_abort = 0; out_ready = 1;
    cyc();
    rst = 0;
  endtask

  task automatic load();
    cfg_load = 1; in_valid = 0;
    cyc();
    cfg_load = 0;
  endtask

  initial begin
    rst = 1; cfg_load = 0; cfg_abort = 0; in_valid = 0; out_ready = 1; in_code = '0;
    cfg_set(0, 0, 0, 0, 1, 0, 1);
    m_ov = 0; m_code = '0; m_mask = '0; m_inj = '0; m_st = 0; m_lfsr = '1;
    m_per = 1; m_reload = 1; l_mode = 0; l_a1 = 0; l_a2 = 0; l_len = 0; l_cnt = 0;
    cyc(); cyc();
    chk("reset_state", 32'(state_o), 0);
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_inj_count", 32'(inj_count), 0);
    rst = 0;

    // Mask shapes: mode, addr1, addr2, len, input word, expected mask
    tbl[0]  = '{0, 5, 0, 0, 13'h0AA, 13'h0020};
    tbl[1]  = '{0, 12, 0, 0, 13'h000, 13'h1000};
    tbl[2]  = '{0, 13, 0, 0, 13'h1FF, 13'h0000};
    tbl[3]  = '{1, 7, 7, 0, 13'h000, 13'h0080};
    tbl[4]  = '{1, 2, 11, 0, 13'h000, 13'h0804};
    tbl[5]  = '{1, 15, 3, 0, 13'h0F0, 13'h0008};
    tbl[6]  = '{1, 0, 12, 0, 13'h1FFF, 13'h1001};
    tbl[7]  = '{2, 10, 0, 5, 13'h000, 13'h1C00};
    tbl[8]  = '{2, 0, 0, 3, 13'h555, 13'h0007};
    tbl[9]  = '{2, 11, 0, 0, 13'h000, 13'h0000};
    tbl[10] = '{2, 14, 0, 4, 13'h123, 13'h0000};
    for (int i = 0; i < 11; i++) begin
      do_reset();
      cfg_set(tbl[i].mode, tbl[i].a1, tbl[i].a2, tbl[i].len, 1, 0, 1);
      load();
      in_valid = 1; in_code = tbl[i].code;
      cyc();
      in_valid = 0;
      chk("tbl_mask", 32'(out_mask), 32'(tbl[i].exp_mask));
      chk("tbl_code", 32'(out_code), 32'(tbl[i].code ^ tbl[i].exp_mask));
    end

    // SINGLE addr 5, three injections then DONE
    do_reset();
    cfg_set(0, 5, 0, 0, 1, 3, 1);
    load();
    in_valid = 1; in_code = '0;
    for (int w = 0; w < 4; w++) begin
      cyc();
      chk("count3_code", 32'(out_code), (w < 3) ? 32'h020 : 32'h000);
    end
    in_valid = 0;
    chk("count3_state", 32'(state_o), 2);
    chk("count3_inj", 32'(inj_count), 3);
    cfg_load = 1; cyc(); cfg_load = 0;
    chk("done_ignores_load", 32'(state_o), 2);

    // Period 3, unlimited count, then backpressure
    do_reset();
    cfg_set(0, 0, 0, 0, 3, 0, 1);
    load();
    in_valid = 1; out_ready = 1;
    for (int w = 1; w <= 9; w++) begin
      in_code = 13'(w * 37);
      cyc();
      chk("period_mask", 32'(out_mask), (w % 3 == 0) ? 32'h1 : 32'h0);
    end
    in_valid = 0; cyc();
    in_valid = 1; in_code = 13'h1A5; out_ready = 0;
    cyc();
    in_code = 13'h05A;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("stall_code", 32'(out_code), 32'h1A5);
      chk("stall_valid", 32'(out_valid), 1);
    end
    out_ready = 1; cyc();
    chk("after_stall_code", 32'(out_code), 32'h05A);
    in_valid = 0; cyc();
    chk("drained", 32'(out_valid), 0);

    // RANDOM with zero seed behaves as all-ones seed
    do_reset();
    cfg_set(3, 0, 0, 0, 1, 0, 0);
    load();
    in_valid = 1; in_code = '0;
    cyc();
    chk("rand_seed0_mask", 32'(out_mask), 32'h004);
    for (int w = 0; w < 999; w++) begin
      in_code = 13'($urandom);
      cyc();
      chk("rand_popcount", 32'($countones(out_mask) >= 1 && $countones(out_mask) <= 2), 1);
    end
    in_valid = 0;

    // Abort mid-ARMED, then reset mid-transfer
    do_reset();
    cfg_set(0, 1, 0, 0, 1, 0, 1);
    load();
    in_valid = 1; in_code = '0; cyc();
    chk("pre_abort_code", 32'(out_code), 32'h002);
    cfg_abort = 1; in_code = 13'h155; cyc(); cfg_abort = 0;
    chk("abort_code", 32'(out_code), 32'h155);
    chk("abort_state", 32'(state_o), 0);
    in_code = 13'h0F0; cyc();
    chk("post_abort_code", 32'(out_code), 32'h0F0);
    in_valid = 0; load();
    in_valid = 1; in_code = '0; out_ready = 0; cyc();
    chk("pre_rst_mask", 32'(out_mask), 32'h002);
    rst = 1; cyc(); rst = 0;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_code", 32'(out_code), 0);
    chk("rst_out_mask", 32'(out_mask), 0);
    chk("rst_inj", 32'(inj_count), 0);
    chk("rst_state", 32'(state_o), 0);
    out_ready = 1; in_code = 13'h0AA; cyc();
    chk("post_rst_code", 32'(out_code), 32'h0AA);
    in_valid = 0;

    // Randomized traffic checked cycle by cycle against the model
    for (int r = 0; r < 20; r++) begin
      cfg_abort = 1; cyc(); cfg_abort = 0;
      cfg_set($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 15),
              $urandom_range(0, 15), $urandom_range(0, 4), $urandom_range(0, 5),
              ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 65535)));
      load();
      for (int c = 0; c < 150; c++) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
        in_code   = 13'($urandom);
        cfg_abort = ($urandom_range(0, 99) < 2);
        cfg_load  = ($urandom_range(0, 99) < 3);
        rst       = ($urandom_range(0, 199) == 0);
        cyc();
      end
      rst = 0; cfg_abort = 0; cfg_load = 0; in_valid = 0; out_ready = 1;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
